pool_nl_unit: RTL
=================

Name: pool_nl_unit

Overview:
- Stage directly downstream of the PE array.
- Consumes the per-lane output bus (one word per buffer lane per valid cycle, row-major raster) and applies 2-D max or average pooling.
- Applies the selected nonlinearity after pooling and streams pooled words towards the output buffers.
- When pooling is disabled, it applies only the nonlinearity, with one register stage.

Parameters:
- N_LANE, `N_BUF: number of parallel lanes, one per PE-array output bus entry.
- WID, `WID_PE_BITS: signed two's-complement data width per lane.
- MAX_ROW, 256: maximum supported row_length.
- ADDR_W, `ADDR_FIFO: width of row_length.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame-start pulse; latches config and clears all counters.
- pool_enable  in  1  1 = pool + NL, 0 = NL bypass.
- pool_type  in  16  0 = max, 1 = average; other values = config error.
- pool_horiz  in  16  horizontal window; legal values 1, 2, 4.
- pool_vert  in  16  vertical window; legal values 1, 2, 4.
- pool_nl  in  3  0 = none, 1 = ReLU; other values = config error.
- row_length  in  ADDR_W  samples per input row; legal range 1..MAX_ROW.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WID x N_LANE  unpacked per-lane samples from the PE array output bus.
- out_valid  out  1  out_data is valid.
- out_data  out  WID x N_LANE  pooled, NL-applied words.
- out_row_end  out  1  with out_valid: last pooled word of an output row.
- cfg_err  out  1  sticky illegal-config flag; cleared by the next start with legal config.

Behaviour:
- Reset: out_valid, out_row_end and cfg_err are 0; out_data is all 0; all counters, accumulators and the row buffer valid state are cleared. Reset mid-frame discards all partial windows.
- Config (pool_enable, pool_type, pool_horiz, pool_vert, pool_nl, row_length) is latched only on start; changes between starts are ignored.
- Illegal latched config sets cfg_err. While cfg_err is set, out_valid stays 0 and inputs are ignored.
- No backpressure: the downstream stage must accept one word per cycle.
- Counters, all lanes in lockstep:
  - col counts 0..row_length-1, wraps to 0 and increments row.
  - hc counts 0..pool_horiz-1.
  - vr = row mod pool_vert.
- Horizontal stage, per lane:
  - Max: h_acc = max(h_acc, x) as a signed compare.
  - Average: h_acc = h_acc + x, with width WID+4.
  - First sample of a window loads h_acc directly.
  - When hc == pool_horiz-1, the horizontal result hr is formed for column index k = col/pool_horiz.
- Row end: trailing samples of an incomplete horizontal window (row_length not a multiple of pool_horiz) are discarded, and hc resets to 0 at the row wrap.
- Vertical stage uses a register-array row buffer of MAX_ROW entries x (WID+4) per lane, read and written in the same cycle:
  - vr == 0: write hr to entry k.
  - 0 < vr < pool_vert-1: write combine(buf[k], hr).
  - vr == pool_vert-1: emit combine(buf[k], hr). No write is needed.
- Average result: sum >>> log2(pool_horiz*pool_vert), arithmetic shift (floor), truncated to WID. The result always fits in WID.
- NL: ReLU maps negative values to 0; none passes the value through.
- Latency: out_valid is asserted exactly 1 cycle after the in_valid cycle that completes a window. Output is registered.
- out_row_end is asserted with the output for the last complete horizontal window of an emitting row.
- Bypass (pool_enable = 0): out_data = NL(in_data) and out_valid = in_valid, both delayed by 1 cycle. Window counters are idle. pool_type, pool_horiz and pool_vert are not checked; pool_nl and row_length are still checked.
- start mid-frame: partial windows and row-buffer contents are abandoned with no output. An output already registered from the previous cycle still appears.
- start with in_valid in the same cycle: start applies first, and the sample is counted as row 0, col 0 under the new config.
- Incomplete final vertical band (frame ends before vr reaches pool_vert-1): no output; it is cleared by the next start.
- horiz = vert = 1 with max: output equals the NL of the input, delayed by 1 cycle.

Test Plan:
- Reset check: assert rst_n = 0 mid-stream -> all outputs go to 0 immediately. After release with no start, in_valid produces no out_valid.
- Max 2x2, row_length = 4, lane 0 rows [1,5,-3,2] and [4,0,7,-8] -> two outputs, 5 then 7 (out_row_end = 1), each 1 cycle after row-1 cols 1 and 3. All lanes are checked independently.
- Average 2x2, lane 0 rows [-1,-2,3,4] and [-3,-4,5,6] -> outputs -3 (floor of -10/4) and 4; with pool_nl = 1 -> outputs 0 and 4.
- Odd row: row_length = 5, max, horiz 2, vert 1, row [1,9,2,8,100] -> outputs 9 and 8 only. The sample 100 is discarded, and out_row_end is asserted with the 8.
- Bypass: pool_enable = 0, pool_nl = 1, inputs -5 then 7 -> outputs 0 then 7, each 1 cycle later.
- Config/abort: start with pool_horiz = 3 -> cfg_err = 1 and no outputs. Next, start with legal 2x2 and inject a mid-frame start after 1.5 rows -> no output from the aborted frame; the new frame pools correctly from its row 0.

Source files
------------

// File: rtl/pool_nl_unit.sv
// pool_nl_unit
//   Sits directly downstream of the PE array. It takes one word per lane per
//   valid cycle in row-major raster order and applies 2-D max or average
//   pooling (window widths 1/2/4 each way). It then applies the selected
//   nonlinearity and streams the pooled words out with one register stage.
//   With pooling disabled, only the nonlinearity is applied, also with one
//   register stage.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            frame start: latches config, clears counters
//   pool_enable      1 = pool + NL, 0 = NL-only bypass
//   pool_type        0 = max, 1 = average
//   pool_horiz/vert  window size, 1/2/4
//   pool_nl          0 = none, 1 = ReLU
//   row_length       samples per input row, 1..MAX_ROW
//   in_valid/in_data per-lane input samples (signed)
//   out_valid/out_data/out_row_end  registered pooled output
//   cfg_err          sticky illegal-config flag, cleared by a legal start
module pool_nl_unit #(
  parameter int N_LANE  = 4,
  parameter int WID     = 16,
  parameter int MAX_ROW = 256,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pool_enable,
  input  logic [15:0]       pool_type,
  input  logic [15:0]       pool_horiz,
  input  logic [15:0]       pool_vert,
  input  logic [2:0]        pool_nl,
  input  logic [ADDR_W-1:0] row_length,
  input  logic              in_valid,
  input  logic [WID-1:0]    in_data [N_LANE],
  output logic              out_valid,
  output logic [WID-1:0]    out_data [N_LANE],
  output logic              out_row_end,
  output logic              cfg_err
);

  localparam int AW = WID + 4;
  localparam int KW = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   run;

  // latched configuration
  logic              en_q, en_d;
  logic              avg_q, avg_d;
  logic              relu_q, relu_d;
  logic [1:0]        lh_q, lh_d;
  logic [1:0]        lv_q, lv_d;
  logic [ADDR_W-1:0] rlen_q, rlen_d;

  // raster / window counters, shared by all lanes
  logic [ADDR_W-1:0] col_q, col_d, c_col;
  logic [1:0]        hc_q, hc_d, c_hc;
  logic [1:0]        vr_q, vr_d, c_vr;
  logic [KW-1:0]     k_q, k_d, c_k;

  logic signed [AW-1:0] hacc_q [N_LANE];
  logic signed [AW-1:0] hacc_d [N_LANE];

  logic              out_valid_q, out_valid_d;
  logic              out_row_end_q, out_row_end_d;
  logic [WID-1:0]    out_data_q [N_LANE];
  logic [WID-1:0]    out_data_d [N_LANE];

  logic signed [AW-1:0] rbuf_q [MAX_ROW][N_LANE];
  logic                 wr_en;
  logic [KW-1:0]        wr_idx;
  logic signed [AW-1:0] wr_data [N_LANE];

  logic signed [AW-1:0] x_s   [N_LANE];
  logic signed [AW-1:0] h_new [N_LANE];
  logic signed [AW-1:0] b_s   [N_LANE];
  logic signed [AW-1:0] v_new [N_LANE];
  logic signed [AW-1:0] win   [N_LANE];
  logic [WID-1:0]       pooled  [N_LANE];
  logic [WID-1:0]       nl_pool [N_LANE];
  logic [WID-1:0]       nl_byp  [N_LANE];

  logic       cfg_ok, h_ok, v_ok;
  logic       e_run;
  logic [1:0] hmax, vmax;
  logic [2:0] sh;

  function automatic logic [1:0] win_log2(input logic [15:0] w);
    case (w)
      16'd2:   return 2'd1;
      16'd4:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Window shape is only checked when pooling is enabled.
  always_comb begin
    h_ok   = (pool_horiz == 16'd1) || (pool_horiz == 16'd2) || (pool_horiz == 16'd4);
    v_ok   = (pool_vert  == 16'd1) || (pool_vert  == 16'd2) || (pool_vert  == 16'd4);
    cfg_ok = (pool_nl <= 3'd1) && (row_length != '0) &&
             (32'(row_length) <= MAX_ROW) &&
             (!pool_enable || ((pool_type <= 16'd1) && h_ok && v_ok));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (start) state_d = cfg_ok ? ST_RUN : ST_ERR;
  end

  // FSM: outputs
  always_comb begin
    run     = (state_q == ST_RUN);
    cfg_err = (state_q == ST_ERR);
  end

  // A start in the same cycle as a sample takes effect first, so the
  // datapath works on the start-adjusted config and counters.
  always_comb begin
    en_d   = start ? pool_enable           : en_q;
    avg_d  = start ? pool_type[0]          : avg_q;
    relu_d = start ? pool_nl[0]            : relu_q;
    lh_d   = start ? win_log2(pool_horiz)  : lh_q;
    lv_d   = start ? win_log2(pool_vert)   : lv_q;
    rlen_d = start ? row_length            : rlen_q;
    e_run  = start ? cfg_ok                : run;

    c_col = start ? '0 : col_q;
    c_hc  = start ? '0 : hc_q;
    c_vr  = start ? '0 : vr_q;
    c_k   = start ? '0 : k_q;

    hmax = (lh_d == 2'd2) ? 2'd3 : lh_d;
    vmax = (lv_d == 2'd2) ? 2'd3 : lv_d;
    sh   = {1'b0, lh_d} + {1'b0, lv_d};

    for (int unsigned l = 0; l < N_LANE; l++) begin
      x_s[l] = AW'($signed(in_data[l]));
      if (c_hc == 2'd0)
        h_new[l] = x_s[l];
      else if (avg_d)
        h_new[l] = hacc_q[l] + x_s[l];
      else
        h_new[l] = (hacc_q[l] > x_s[l]) ? hacc_q[l] : x_s[l];

      b_s[l] = rbuf_q[c_k][l];
      if (avg_d) v_new[l] = b_s[l] + h_new[l];
      else       v_new[l] = (b_s[l] > h_new[l]) ? b_s[l] : h_new[l];

      // first row of a band starts fresh; later rows fold in the buffer
      win[l]     = (c_vr == 2'd0) ? h_new[l] : v_new[l];
      pooled[l]  = WID'(avg_d ? (win[l] >>> sh) : win[l]);
      nl_pool[l] = (relu_d && pooled[l][WID-1]) ? '0 : pooled[l];
      nl_byp[l]  = (relu_d && in_data[l][WID-1]) ? '0 : in_data[l];
    end

    col_d         = c_col;
    hc_d          = c_hc;
    vr_d          = c_vr;
    k_d           = c_k;
    out_valid_d   = 1'b0;
    out_row_end_d = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = c_k;
    for (int unsigned l = 0; l < N_LANE; l++) begin
      hacc_d[l]     = hacc_q[l];
      out_data_d[l] = out_data_q[l];
      wr_data[l]    = win[l];
    end

    if (in_valid && e_run) begin
      if (!en_d) begin
        out_valid_d = 1'b1;
        for (int unsigned l = 0; l < N_LANE; l++) out_data_d[l] = nl_byp[l];
      end else begin
        for (int unsigned l = 0; l < N_LANE; l++) hacc_d[l] = h_new[l];
        if (c_hc == hmax) begin
          if (c_vr == vmax) begin
            out_valid_d = 1'b1;
            for (int unsigned l = 0; l < N_LANE; l++) out_data_d[l] = nl_pool[l];
            // last full window of the row: no further window fits after it
            out_row_end_d = ({1'b0, c_col} + {{(ADDR_W-1){1'b0}}, hmax} + 1'b1)
                            >= {1'b0, rlen_d};
          end else begin
            wr_en = 1'b1;
          end
        end
        if (c_col == rlen_d - 1'b1) begin
          col_d = '0;
          hc_d  = '0;
          k_d   = '0;
          vr_d  = (c_vr == vmax) ? 2'd0 : c_vr + 2'd1;
        end else begin
          col_d = c_col + 1'b1;
          if (c_hc == hmax) begin
            hc_d = '0;
            k_d  = c_k + 1'b1;
          end else begin
            hc_d = c_hc + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q          <= 1'b0;
      avg_q         <= 1'b0;
      relu_q        <= 1'b0;
      lh_q          <= '0;
      lv_q          <= '0;
      rlen_q        <= '0;
      col_q         <= '0;
      hc_q          <= '0;
      vr_q          <= '0;
      k_q           <= '0;
      out_valid_q   <= 1'b0;
      out_row_end_q <= 1'b0;
      for (int unsigned l = 0; l < N_LANE; l++) begin
        hacc_q[l]     <= '0;
        out_data_q[l] <= '0;
      end
    end else begin
      en_q          <= en_d;
      avg_q         <= avg_d;
      relu_q        <= relu_d;
      lh_q          <= lh_d;
      lv_q          <= lv_d;
      rlen_q        <= rlen_d;
      col_q         <= col_d;
      hc_q          <= hc_d;
      vr_q          <= vr_d;
      k_q           <= k_d;
      out_valid_q   <= out_valid_d;
      out_row_end_q <= out_row_end_d;
      for (int unsigned l = 0; l < N_LANE; l++) begin
        hacc_q[l]     <= hacc_d[l];
        out_data_q[l] <= out_data_d[l];
      end
    end
  end

  // Row buffer holds no reset: every band overwrites an entry (vr == 0)
  // before any later row reads it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned l = 0; l < N_LANE; l++) rbuf_q[wr_idx][l] <= wr_data[l];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_row_end = out_row_end_q;
  assign out_data    = out_data_q;

endmodule
